// File: rtl/fir_if.sv
// fir_if: start/done handshake, sample/coefficient RAM ports and DC enable for fir_filter.
interface fir_if #(
   parameter int ADDR_SIZE = 5,
   parameter int DATA_SIZE = 16,
   parameter int COEF_SIZE = 32
);
   logic                 ap_start;
   logic                 ap_done;
   logic                 ap_idle;
   logic                 ap_ready;
   logic [DATA_SIZE-1:0] ap_return;
   logic [ADDR_SIZE-1:0] x_ant_address0;
   logic                 x_ant_ce0;
   logic [DATA_SIZE-1:0] x_ant_q0;
   logic [ADDR_SIZE-1:0] x_coefs_address0;
   logic                 x_coefs_ce0;
   logic [COEF_SIZE-1:0] x_coefs_q0;
   logic                 dcValEn;
   modport master (
      output ap_start, dcValEn, x_ant_q0, x_coefs_q0,
      input  ap_done, ap_idle, ap_ready, ap_return,
             x_ant_address0, x_ant_ce0, x_coefs_address0, x_coefs_ce0
   );
   modport slave (
      input  ap_start, dcValEn, x_ant_q0, x_coefs_q0,
      output ap_done, ap_idle, ap_ready, ap_return,
             x_ant_address0, x_ant_ce0, x_coefs_address0, x_coefs_ce0
   );
endinterface

// File: rtl/fir_filter.sv
// fir_filter: M-tap FIR multiply-accumulate per start/done call, saturated unsigned result.
// Define FIR_ROUND_EN for round-half-up before the fractional shift (default truncates).
module fir_filter #(
   parameter int M         = 23,
   parameter int ADDR_SIZE = 5,
   parameter int DATA_SIZE = 16,
   parameter int COEF_SIZE = 32,
   parameter int COEF_FRAC = 16,
   parameter int DC_VAL    = 2048
) (
   input logic ap_clk,
   input logic ap_rst,
   fir_if.slave bus
);
   localparam int PW = DATA_SIZE + COEF_SIZE;
   localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, FINISH = 2'd3;
   localparam logic signed [63:0] MAXV = (64'sd1 <<< DATA_SIZE) - 64'sd1;
   localparam logic signed [63:0] DCV  = 64'(DC_VAL);
`ifdef FIR_ROUND_EN
   localparam logic signed [63:0] RND  = 64'sd1 <<< (COEF_FRAC - 1);
`else
   localparam logic signed [63:0] RND  = 64'sd0;
`endif
   logic [1:0]           state;
   logic [ADDR_SIZE-1:0] k;
   logic signed [PW-1:0] p;
   logic signed [63:0]   acc, sum, y;
   logic [DATA_SIZE-1:0] ret;
   assign p   = $signed({{COEF_SIZE{1'b0}}, bus.x_ant_q0})
              * $signed({{DATA_SIZE{bus.x_coefs_q0[COEF_SIZE-1]}}, bus.x_coefs_q0});
   assign sum = acc + 64'(p);
   assign y   = ((sum + RND) >>> COEF_FRAC) + (bus.dcValEn ? DCV : 64'sd0);
   assign ret = y < 64'sd0 ? '0 : (y > MAXV ? '1 : y[DATA_SIZE-1:0]);
   assign bus.ap_idle          = state == IDLE;
   assign bus.ap_done          = state == FINISH;
   assign bus.ap_ready         = state == FINISH;
   assign bus.x_ant_ce0        = state == READ;
   assign bus.x_coefs_ce0      = state == READ;
   assign bus.x_ant_address0   = state == READ ? k : ADDR_SIZE'(M);
   assign bus.x_coefs_address0 = state == READ ? k : ADDR_SIZE'(M);
   // q0 lags the address by one cycle, so the read at k=0 carries no tap yet
   always_ff @(posedge ap_clk or posedge ap_rst)
      if (ap_rst) begin
         state         <= IDLE;
         k             <= '0;
         acc           <= '0;
         bus.ap_return <= '0;
      end else
         case (state)
            IDLE, FINISH:
               if (bus.ap_start) begin
                  state <= READ;
                  k     <= '0;
                  acc   <= '0;
               end else
                  state <= IDLE;
            READ: begin
               acc   <= k == '0 ? '0 : sum;
               k     <= k + 1'b1;
               state <= k == ADDR_SIZE'(M - 1) ? DRAIN : READ;
            end
            DRAIN: begin
               acc           <= sum;
               bus.ap_return <= ret;
               state         <= FINISH;
            end
         endcase
endmodule

// File: tb/tb_fir_filter.sv
// tb_fir_filter: directed and randomized calls checked against an arithmetic FIR reference.
module tb_fir_filter;
   localparam int M = 23;
   logic clk = 0;
   logic rst = 1;
   int   vecs = 0;
   int   errs = 0;
   logic [15:0]        xm[32];
   logic signed [31:0] cm[32];
   fir_if bus ();
   fir_filter dut (.ap_clk(clk), .ap_rst(rst), .bus(bus));
   always #5 clk = ~clk;
   // Sample/coefficient RAMs with one cycle of read latency
   always @(posedge clk) begin
      if (bus.x_ant_ce0) bus.x_ant_q0 <= xm[bus.x_ant_address0];
      if (bus.x_coefs_ce0) bus.x_coefs_q0 <= cm[bus.x_coefs_address0];
   end
   task automatic chk(input string tag, input longint got, input longint exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   function automatic longint model(input bit dc);
      longint s = 0;
      for (int i = 0; i < M; i++) s += longint'(xm[i]) * longint'(cm[i]);
`ifdef FIR_ROUND_EN
      s += 32768;
`endif
      s = s >>> 16;
      if (dc) s += 2048;
      return s < 0 ? 0 : (s > 65535 ? 65535 : s);
   endfunction
   task automatic clear_mem();
      for (int i = 0; i < 32; i++) begin
         xm[i] = '0;
         cm[i] = '0;
      end
   endtask
   task automatic do_call(input string tag, input bit dc, input int hold, input longint want);
      int n = 0;
      bit seen = 0;
      @(negedge clk);
      bus.ap_start = 1;
      bus.dcValEn  = dc;
      @(posedge clk);
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (n >= hold) bus.ap_start = 0;
         chk({tag, "_idle"}, bus.ap_idle, 0);
         if (!bus.x_ant_ce0) chk({tag, "_park"}, bus.x_ant_address0, M);
         if (bus.ap_done) seen = 1;
      end
      chk({tag, "_latency"}, n, M + 2);
      chk({tag, "_ready"}, bus.ap_ready, 1);
      chk({tag, "_result"}, bus.ap_return, want);
      @(negedge clk);
      chk({tag, "_idle_after"}, bus.ap_idle, 1);
      chk({tag, "_done_low"}, bus.ap_done, 0);
      chk({tag, "_hold_ret"}, bus.ap_return, want);
   endtask
   initial begin
      int n, last, dones;
      bus.ap_start = 0;
      bus.dcValEn  = 0;
      clear_mem();
      repeat (2) @(negedge clk);
      chk("rst_done", bus.ap_done, 0);
      chk("rst_ready", bus.ap_ready, 0);
      chk("rst_idle", bus.ap_idle, 1);
      chk("rst_ret", bus.ap_return, 0);
      chk("rst_ce", {bus.x_ant_ce0, bus.x_coefs_ce0}, 0);
      chk("rst_addr_x", bus.x_ant_address0, M);
      chk("rst_addr_c", bus.x_coefs_address0, M);
      rst = 0;
      cm[0] = 65536; xm[0] = 1234;
      do_call("impulse", 0, 1, 1234);
      for (int i = 0; i < M; i++) begin cm[i] = 65536; xm[i] = 100; end
      do_call("box", 0, 1, 2300);
      do_call("box_dc", 1, 1, 4348);
      for (int i = 0; i < M; i++) xm[i] = 16'hFFFF;
      do_call("sat_hi", 0, 1, 65535);
      clear_mem();
      cm[0] = -65536; xm[0] = 5;
      do_call("sat_lo", 0, 1, 0);
      cm[0] = 32768; xm[0] = 3;
`ifdef FIR_ROUND_EN
      do_call("round", 0, 1, 2);
`else
      do_call("trunc", 0, 1, 1);
`endif
      for (int i = 0; i < M; i++) begin
         xm[i] = 16'($urandom);
         cm[i] = 32'(int'($urandom_range(0, 262143)) - 131072);
      end
      do_call("hold3", 0, 3, model(0));
      dones = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus.ap_done) dones++;
      end
      chk("hold3_single", dones, 0);
      @(negedge clk);
      bus.ap_start = 1;
      @(posedge clk);
      n = 0; last = 0; dones = 0;
      while (dones < 3 && n < 100) begin
         @(negedge clk);
         n++;
         chk("b2b_idle", bus.ap_idle, 0);
         if (bus.ap_done) begin
            dones++;
            chk("b2b_gap", n - last, M + 2);
            chk("b2b_result", bus.ap_return, model(0));
            last = n;
            if (dones == 3) bus.ap_start = 0;
         end
      end
      bus.ap_start = 0;
      chk("b2b_count", dones, 3);
      @(negedge clk);
      chk("b2b_idle_end", bus.ap_idle, 1);
      @(negedge clk);
      bus.ap_start = 1;
      n = 0;
      while (n < 40 && !(bus.x_ant_ce0 && bus.x_ant_address0 == 10)) begin
         @(negedge clk);
         bus.ap_start = 0;
         n++;
      end
      chk("mid_reach_k10", bus.x_ant_address0, 10);
      rst = 1;
      #1;
      chk("mid_done", bus.ap_done, 0);
      chk("mid_idle", bus.ap_idle, 1);
      chk("mid_ret", bus.ap_return, 0);
      chk("mid_ce", {bus.x_ant_ce0, bus.x_coefs_ce0}, 0);
      chk("mid_addr", bus.x_coefs_address0, M);
      dones = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.ap_done) dones++;
      end
      rst = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus.ap_done) dones++;
      end
      chk("mid_no_done", dones, 0);
      do_call("after_rst", 0, 1, model(0));
      for (int t = 0; t < 8; t++) begin
         bit dc = 1'($urandom);
         for (int i = 0; i < M; i++) begin
            xm[i] = 16'($urandom);
            cm[i] = (t % 2) ? 32'($urandom) : 32'(int'($urandom_range(0, 32767)) - 8192);
         end
         do_call("random", dc, 1, model(dc));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
